// File: rtl/mlblock_pkg.sv
// Shared types and helpers for the mlblock_2dflex_v3 MAC array.
// sat_add is only called when MLBLOCK_SATURATE_EN is defined.
package mlblock_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    localparam int unsigned SAT_MAX_W = 64;

    // Adds two w-bit values held in the low bits and clamps to the w-bit range of the mode.
    function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                     input logic [SAT_MAX_W-1:0] b,
                                                     input int unsigned w,
                                                     input logic sgn);
        logic [SAT_MAX_W:0]   s;
        logic [SAT_MAX_W-1:0] mask;
        mask = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        s    = {1'b0, a & mask} + {1'b0, b & mask};
        if (sgn) begin
            if ((a[w-1] == b[w-1]) && (s[w-1] != a[w-1]))
                return a[w-1] ? (SAT_MAX_W'(1) << (w - 1)) : (mask >> 1);
            return s[SAT_MAX_W-1:0] & mask;
        end
        if (s[w])
            return mask;
        return s[SAT_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/mlblock_2dflex_v3_if.sv
// Data, weight, cascade, result and configuration signals of mlblock_2dflex_v3.
interface mlblock_2dflex_v3_if #(
    parameter int MAC_UNITS = 4,
    parameter int I_W       = 8,
    parameter int W_W       = 8,
    parameter int RES_W     = 32
);
    logic                       I_en;
    logic                       I_ready;
    logic [MAC_UNITS*I_W-1:0]   I_in;
    logic                       W_en;
    logic [W_W-1:0]             W_in;
    logic [W_W-1:0]             W_out;
    logic [MAC_UNITS*RES_W-1:0] Res_cas_in;
    logic                       Res_cas_in_zero;
    logic [MAC_UNITS*RES_W-1:0] Res_out;
    logic                       Res_valid;
    logic                       Res_ready;
    logic [MAC_UNITS*RES_W-1:0] Res_cas_out;
    logic                       config_en;
    logic                       config_in;
    logic                       config_out;

    modport master (
        output I_en, I_in, W_en, W_in, Res_cas_in, Res_cas_in_zero, Res_ready,
               config_en, config_in,
        input  I_ready, W_out, Res_out, Res_valid, Res_cas_out, config_out
    );

    modport slave (
        input  I_en, I_in, W_en, W_in, Res_cas_in, Res_cas_in_zero, Res_ready,
               config_en, config_in,
        output I_ready, W_out, Res_out, Res_valid, Res_cas_out, config_out
    );
endinterface

// File: rtl/mlblock_mac_lane.sv
// One MAC lane: weight register, multiplier, accumulator and cascade add into the result.
// Additions clamp when MLBLOCK_SATURATE_EN is defined, otherwise wrap.
module mlblock_mac_lane
    import mlblock_pkg::*;
#(
    parameter int I_W   = 8,
    parameter int W_W   = 8,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             conf_signed_i,
    input  logic             clr_i,
    input  logic             beat_i,
    input  logic             last_i,
    input  logic             w_en_i,
    input  logic [W_W-1:0]   w_i,
    output logic [W_W-1:0]   w_o,
    input  logic [I_W-1:0]   i_i,
    input  logic [RES_W-1:0] cas_i,
    input  logic             cas_zero_i,
    output logic [RES_W-1:0] res_o
);
    logic        [W_W-1:0]       w_q;
    logic        [RES_W-1:0]     acc_q, acc_d;
    logic        [RES_W-1:0]     res_q, res_d;
    logic signed [I_W:0]         i_ext;
    logic signed [W_W:0]         w_ext;
    logic signed [I_W+W_W+1:0]   prod_full;
    logic        [RES_W-1:0]     prod;
    logic        [RES_W-1:0]     cas_eff;

`ifdef MLBLOCK_SATURATE_EN
    function automatic logic [RES_W-1:0] add_res(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
        logic [SAT_MAX_W-1:0] s;
        s = sat_add(SAT_MAX_W'(a), SAT_MAX_W'(b), RES_W, conf_signed_i);
        return s[RES_W-1:0];
    endfunction
`else
    function automatic logic [RES_W-1:0] add_res(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
        return a + b;
    endfunction
`endif

    // An extra top bit carries the sign in signed mode and is zero in unsigned mode.
    assign i_ext     = {conf_signed_i & i_i[I_W-1], i_i};
    assign w_ext     = {conf_signed_i & w_q[W_W-1], w_q};
    assign prod_full = i_ext * w_ext;
    assign prod      = RES_W'(prod_full);
    assign cas_eff   = cas_zero_i ? '0 : cas_i;
    assign acc_d     = add_res(acc_q, prod);
    assign res_d     = add_res(acc_d, cas_eff);
    assign w_o       = w_q;
    assign res_o     = res_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else begin
            if (w_en_i)
                w_q <= w_i;
            if (clr_i) begin
                acc_q <= '0;
            end else if (beat_i) begin
                if (last_i) begin
                    acc_q <= '0;
                    res_q <= res_d;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    end
endmodule

// File: rtl/mlblock_2dflex_v3.sv
// MAC array top: beat-count FSM, serial configuration chain and result handshake.
// Optional saturating arithmetic is enabled with MLBLOCK_SATURATE_EN.
module mlblock_2dflex_v3
    import mlblock_pkg::*;
#(
    parameter int MAC_UNITS  = 4,
    parameter int I_W        = 8,
    parameter int W_W        = 8,
    parameter int RES_W      = 32,
    parameter int ACC_D_LOG2 = 4
) (
    input logic               clk,
    input logic               reset,
    mlblock_2dflex_v3_if.slave bus
);
    state_e                     state_q;
    logic [ACC_D_LOG2-1:0]      cnt_q;
    logic [ACC_D_LOG2-1:0]      depth_q;
    logic                       sgn_q;
    logic                       valid_q, valid_d;
    logic                       beat, last;
    logic [W_W-1:0]             w_chain [MAC_UNITS+1];
    logic [RES_W-1:0]           res_lane [MAC_UNITS];
    logic [MAC_UNITS*RES_W-1:0] res_flat;

    // Configuration shifting takes priority over input beats.
    assign bus.I_ready    = !valid_q || bus.Res_ready;
    assign beat           = bus.I_en && bus.I_ready && !bus.config_en;
    assign last           = beat && (cnt_q == depth_q);
    assign valid_d        = last ? 1'b1 : (bus.Res_ready ? 1'b0 : valid_q);
    assign w_chain[0]     = bus.W_in;
    assign bus.W_out      = w_chain[MAC_UNITS];
    assign bus.config_out = depth_q[ACC_D_LOG2-1];
    assign bus.Res_valid  = valid_q;
    assign bus.Res_out    = res_flat;
    assign bus.Res_cas_out = res_flat;

    always_comb begin
        res_flat = '0;
        for (int k = 0; k < MAC_UNITS; k++)
            res_flat[k*RES_W +: RES_W] = res_lane[k];
    end

    for (genvar k = 0; k < MAC_UNITS; k++) begin : g_lane
        mlblock_mac_lane #(.I_W(I_W), .W_W(W_W), .RES_W(RES_W)) u_lane (
            .clk           (clk),
            .reset         (reset),
            .conf_signed_i (sgn_q),
            .clr_i         (bus.config_en),
            .beat_i        (beat),
            .last_i        (last),
            .w_en_i        (bus.W_en),
            .w_i           (w_chain[k]),
            .w_o           (w_chain[k+1]),
            .i_i           (bus.I_in[k*I_W +: I_W]),
            .cas_i         (bus.Res_cas_in[k*RES_W +: RES_W]),
            .cas_zero_i    (bus.Res_cas_in_zero),
            .res_o         (res_lane[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            depth_q <= '0;
            sgn_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (bus.config_en) begin
                sgn_q   <= bus.config_in;
                depth_q <= (depth_q << 1) | ACC_D_LOG2'(sgn_q);
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end else if (beat) begin
                case (state_q)
                    ST_IDLE: if (!last) begin
                        state_q <= ST_ACC;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                    ST_ACC: if (last) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mlblock_2dflex_v3.sv
// Scoreboard bench for mlblock_2dflex_v3: a 32-bit result instance plus a 16-bit one for overflow.
module tb_mlblock_2dflex_v3;
    localparam int MU = 4, IW = 8, WW = 8, RW = 32, RWB = 16, AD = 4;

    logic clk = 1'b0;
    logic reset;
    initial forever #5 clk = ~clk;

    mlblock_2dflex_v3_if #(.MAC_UNITS(MU), .I_W(IW), .W_W(WW), .RES_W(RW))  busa ();
    mlblock_2dflex_v3_if #(.MAC_UNITS(MU), .I_W(IW), .W_W(WW), .RES_W(RWB)) busb ();

    mlblock_2dflex_v3 #(.MAC_UNITS(MU), .I_W(IW), .W_W(WW), .RES_W(RW), .ACC_D_LOG2(AD))
        dut_a (.clk(clk), .reset(reset), .bus(busa));
    mlblock_2dflex_v3 #(.MAC_UNITS(MU), .I_W(IW), .W_W(WW), .RES_W(RWB), .ACC_D_LOG2(AD))
        dut_b (.clk(clk), .reset(reset), .bus(busb));

    logic             i_en, w_en, cfg_en, cfg_in, res_ready, cas_zero, selb;
    logic [MU*IW-1:0] i_in;
    logic [WW-1:0]    w_in;
    logic [MU*RW-1:0] cas_in;

    assign busa.I_en            = i_en & ~selb;
    assign busa.I_in            = i_in;
    assign busa.W_en            = w_en & ~selb;
    assign busa.W_in            = w_in;
    assign busa.config_en       = cfg_en & ~selb;
    assign busa.config_in       = cfg_in;
    assign busa.Res_ready       = res_ready;
    assign busa.Res_cas_in      = cas_in;
    assign busa.Res_cas_in_zero = cas_zero;

    assign busb.I_en            = i_en & selb;
    assign busb.I_in            = i_in;
    assign busb.W_en            = w_en & selb;
    assign busb.W_in            = w_in;
    assign busb.config_en       = cfg_en & selb;
    assign busb.config_in       = cfg_in;
    assign busb.Res_ready       = res_ready;
    assign busb.Res_cas_in      = '0;
    assign busb.Res_cas_in_zero = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [MU*RW-1:0]  qa[$];
    logic [MU*RWB-1:0] qb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (busa.Res_valid === 1'b1 && busa.Res_ready === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resA_unexpected: got %h expected no result", busa.Res_out);
            end else begin
                logic [MU*RW-1:0] e;
                e = qa.pop_front();
                chk("resA", busa.Res_out, e);
                chk("casoutA", busa.Res_cas_out, e);
            end
        end
        if (busb.Res_valid === 1'b1 && busb.Res_ready === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resB_unexpected: got %h expected no result", busb.Res_out);
            end else begin
                chk("resB", busb.Res_out, qb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy();
        return selb ? busb.I_ready : busa.I_ready;
    endfunction

    task automatic beat(input logic [MU*IW-1:0] v);
        int n;
        n    = 0;
        i_in = v;
        i_en = 1'b1;
        while (!rdy() && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL beat_ready_timeout: got I_ready 0 expected 1 within 50 cycles");
        end
        step();
        i_en = 1'b0;
    endtask

    task automatic wload(input logic [WW-1:0] v);
        w_in = v;
        w_en = 1'b1;
        step();
        w_en = 1'b0;
    endtask

    task automatic cfg(input logic sgn, input logic [AD-1:0] d);
        cfg_en = 1'b1;
        for (int i = AD - 1; i >= 0; i--) begin
            cfg_in = d[i];
            step();
        end
        cfg_in = sgn;
        step();
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    function automatic logic [MU*IW-1:0] splat(input logic [IW-1:0] b);
        return {MU{b}};
    endfunction

    initial begin
        logic [MU*RWB-1:0] expb;
        int n;
        i_en = 0; w_en = 0; cfg_en = 0; cfg_in = 0; res_ready = 0;
        cas_zero = 1; selb = 0; i_in = '0; w_in = '0; cas_in = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_I_ready", busa.I_ready, 1);
        chk("rst_Res_valid", busa.Res_valid, 0);
        chk("rst_W_out", busa.W_out, 0);
        chk("rst_config_out", busa.config_out, 0);
        chk("rst_Res_out", busa.Res_out, 0);
        chk("rst_B_Res_valid", busb.Res_valid, 0);

        wload(8'd4); wload(8'd3); wload(8'd2);
        chk("w_out_3shifts", busa.W_out, 0);
        wload(8'd1);
        chk("w_out_4shifts", busa.W_out, 4);

        res_ready = 1'b1;
        cfg(1'b0, 4'd3);
        chk("config_out_d3", busa.config_out, 0);
        qa.push_back({32'd160, 32'd120, 32'd80, 32'd40});
        beat(splat(8'd10)); beat(splat(8'd10)); beat(splat(8'd10));
        chk("valid_before_last", busa.Res_valid, 0);
        beat(splat(8'd10));
        chk("valid_after_last", busa.Res_valid, 1);
        step();
        chk("valid_cleared", busa.Res_valid, 0);

        res_ready = 1'b0;
        qa.push_back({32'd16, 32'd12, 32'd8, 32'd4});
        repeat (4) beat(splat(8'd1));
        chk("stall_I_ready", busa.I_ready, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_I_ready_hold", busa.I_ready, 0);
            chk("stall_Res_out_hold", busa.Res_out, {32'd16, 32'd12, 32'd8, 32'd4});
        end
        res_ready = 1'b1;
        step();
        chk("release_valid", busa.Res_valid, 0);
        chk("release_I_ready", busa.I_ready, 1);

        wload(8'd3);
        chk("w_out_after_shift", busa.W_out, 3);
        cfg(1'b1, 4'd0);
        qa.push_back({32'd0, 32'd0, 32'd0, 32'hFFFF_FFFA});
        beat(32'h0000_00FE);
        cfg(1'b0, 4'd0);
        qa.push_back({32'd0, 32'd0, 32'd0, 32'd762});
        beat(32'h0000_00FE);
        cas_in   = {32'd0, 32'd0, 32'd5, 32'd100};
        cas_zero = 1'b0;
        qa.push_back({32'd0, 32'd0, 32'd5, 32'd862});
        beat(32'h0000_00FE);
        cas_zero = 1'b1;
        qa.push_back({32'd0, 32'd0, 32'd0, 32'd762});
        beat(32'h0000_00FE);
        cas_in = '0;

        qa.push_back({32'd6, 32'd4, 32'd2, 32'd6});
        qa.push_back({32'd9, 32'd6, 32'd3, 32'd9});
        beat(splat(8'd2));
        beat(splat(8'd3));
        chk("b2b_valid_held", busa.Res_valid, 1);
        chk("b2b_second_result", busa.Res_out, {32'd9, 32'd6, 32'd3, 32'd9});

        cfg(1'b0, 4'd8);
        chk("config_out_d8", busa.config_out, 1);

        cfg(1'b0, 4'd3);
        beat(splat(8'd7));
        beat(splat(8'd7));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_valid", busa.Res_valid, 0);
        chk("midrst_W_out", busa.W_out, 0);
        chk("midrst_config_out", busa.config_out, 0);
        chk("midrst_I_ready", busa.I_ready, 1);
        wload(8'd4); wload(8'd3); wload(8'd2); wload(8'd1);
        cfg(1'b0, 4'd3);
        qa.push_back({32'd16, 32'd12, 32'd8, 32'd4});
        repeat (4) beat(splat(8'd1));

        selb = 1'b1;
        repeat (4) wload(8'd127);
        chk("B_W_out", busb.W_out, 127);
        cfg(1'b1, 4'd3);
`ifdef MLBLOCK_SATURATE_EN
        expb = {4{16'h7FFF}};
`else
        expb = {4{16'hFC04}};
`endif
        qb.push_back(expb);
        repeat (4) beat(splat(8'd127));
        selb = 1'b0;

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            step();
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d pending results expected 0", qa.size(), qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
